// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {Cout,Sum} = A + B + Cin, with a valid qualifier.
// Latency: 1 clock from an in_valid=1 edge to Sum/Cout/out_valid.
// Backpressure: none; one result per valid input, held (with out_valid=0) on idle cycles.

// One-bit full-adder cell, the leaf of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid
);
    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             cout_d,  cout_q;
    logic             valid_d, valid_q;

    assign carry[0] = Cin;

    // One cell per bit; the carry ripples from bit 0 upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum_comb[i]),
            .co (carry[i+1])
        );
    end

    // Capture a new result only on valid cycles so idle-cycle inputs (even X) never reach the flops.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
        if (in_valid) begin
            sum_d   = sum_comb;
            cout_d  = carry[WIDTH];
            valid_d = 1'b1;
        end
    end

    // Output registers; reset clears them immediately and drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;
    logic clk;
    logic rst_n;

    logic       v1, a1, b1, c1, s1, co1, ov1;
    logic       v4, c4, co4, ov4;
    logic [3:0] a4, b4, s4;
    logic       v8, c8, co8, ov8;
    logic [7:0] a8, b8, s8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t tbl1[8];
    vec_t tbl4[3];

    // Scoreboard queues of expected {Cout,Sum}, pushed at drive time.
    logic [1:0] q1[$];
    logic [4:0] q4[$];
    logic [8:0] q8[$];

    full_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
        .Sum(s1), .Cout(co1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .A(a4), .B(b4), .Cin(c4),
        .Sum(s4), .Cout(co4), .out_valid(ov4)
    );
    full_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8), .Cin(c8),
        .Sum(s8), .Cout(co8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] held8;
        logic       pend8;
        logic [8:0] e8;
        logic [4:0] e4;
        logic [1:0] e1;

        // WIDTH=1 truth table: {A,B,Cin} -> Sum,Cout.
        tbl1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
        tbl1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0};
        tbl1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0};
        tbl1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
        tbl1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
        tbl1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1};
        tbl1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1};
        tbl1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};
        // WIDTH=4 wrap-around and plain cases.
        tbl4[0] = '{8'hF, 8'hF, 1'b1, 8'hF, 1'b1};
        tbl4[1] = '{8'hF, 8'h0, 1'b1, 8'h0, 1'b1};
        tbl4[2] = '{8'h5, 8'h3, 1'b0, 8'h8, 1'b0};

        rst_n = 1'b0;
        v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        v4 = 0; a4 = 0; b4 = 0; c4 = 0;
        v8 = 0; a8 = 0; b8 = 0; c8 = 0;

        #12;
        chk("reset_w1", {13'd0, ov1, co1, s1}, 16'd0);
        chk("reset_w4", {10'd0, ov4, co4, s4}, 16'd0);
        chk("reset_w8", {6'd0, ov8, co8, s8}, 16'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 walk, back-to-back valid.
        for (int i = 0; i < 8; i++) begin
            a1 = tbl1[i].a[0]; b1 = tbl1[i].b[0]; c1 = tbl1[i].cin; v1 = 1'b1;
            q1.push_back({tbl1[i].co, tbl1[i].s[0]});
            step();
            e1 = q1.pop_front();
            chk($sformatf("w1_vec%0d", i), {13'd0, ov1, co1, s1}, {13'd0, 1'b1, e1});
        end
        v1 = 1'b0;

        // WIDTH=4 table.
        for (int i = 0; i < 3; i++) begin
            a4 = tbl4[i].a[3:0]; b4 = tbl4[i].b[3:0]; c4 = tbl4[i].cin; v4 = 1'b1;
            q4.push_back({tbl4[i].co, tbl4[i].s[3:0]});
            step();
            e4 = q4.pop_front();
            chk($sformatf("w4_vec%0d", i), {10'd0, ov4, co4, s4}, {10'd0, 1'b1, e4});
        end

        // Single valid then two idle cycles with junk inputs: result held, valid drops.
        a4 = 4'd1; b4 = 4'd2; c4 = 1'b0; v4 = 1'b1;
        step();
        chk("hold_first", {10'd0, ov4, co4, s4}, {10'd0, 1'b1, 1'b0, 4'd3});
        for (int i = 0; i < 2; i++) begin
            v4 = 1'b0;
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            c4 = 1'($urandom_range(0, 1));
            step();
            chk($sformatf("hold_idle%0d", i), {10'd0, ov4, co4, s4}, {10'd0, 1'b0, 1'b0, 4'd3});
        end

        // Register Sum=1,Cout=1, then reset between edges.
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b1; v4 = 1'b1;
        step();
        chk("pre_reset", {10'd0, ov4, co4, s4}, {10'd0, 1'b1, 1'b1, 4'd1});
        v4 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_w4", {10'd0, ov4, co4, s4}, 16'd0);
        @(negedge clk);
        chk("reset_held_w4", {10'd0, ov4, co4, s4}, 16'd0);
        rst_n = 1'b1;
        step();
        chk("post_release", {10'd0, ov4, co4, s4}, 16'd0);

        // WIDTH=8 random stream with random in_valid.
        held8 = 9'd0;
        pend8 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            v8 = 1'($urandom_range(0, 1));
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            c8 = 1'($urandom_range(0, 1));
            if (v8) q8.push_back(9'(a8) + 9'(b8) + 9'(c8));
            pend8 = v8;
            step();
            if (pend8 && q8.size() != 0) begin
                e8 = q8.pop_front();
                held8 = e8;
            end
            chk("w8_rand", {6'd0, ov8, co8, s8}, {6'd0, pend8, held8});
        end
        v8 = 1'b0;
        chk("w8_queue_empty", 16'(q8.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
